// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI memory arbiter.
// Holds the FSM state enum, SPI commands, size codes and port ids.
package spi_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_FINISH
   } state_e;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_WRITE     = 8'h02;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: DIV prescaler, sclk, tx/rx shifters, bit count.
// Ports: start/n_bits/tx_word in; sclk/mosi/busy/last/rx_word out; miso in.
module spi_shift_engine #(
   parameter int DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [6:0]  n_bits,
   input  logic [63:0] tx_word,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        busy,
   output logic        last,
   output logic [31:0] rx_word
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);

   logic [CW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic          busy_q, busy_d;
   logic [6:0]    bit_q, bit_d;
   logic [6:0]    n_q, n_d;
   logic [63:0]   tx_q, tx_d;
   logic [31:0]   rx_q, rx_d;
   logic          tick;

   assign tick = busy_q && (div_q == DIV_MAX);
   // final falling edge of the frame
   assign last = tick && sclk_q && (bit_q == n_q - 7'd1);

   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      busy_d = busy_q;
      bit_d  = bit_q;
      n_d    = n_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      if (start) begin
         div_d  = '0;
         sclk_d = 1'b0;
         busy_d = 1'b1;
         bit_d  = '0;
         n_d    = n_bits;
         tx_d   = tx_word;
         rx_d   = '0;
      end else if (busy_q) begin
         if (tick) begin
            div_d  = '0;
            sclk_d = !sclk_q;
            if (!sclk_q) begin
               rx_d = {rx_q[30:0], miso};
            end else begin
               bit_d = bit_q + 7'd1;
               tx_d  = {tx_q[62:0], 1'b0};
               if (last) begin
                  busy_d = 1'b0;
                  tx_d   = '0;
               end
            end
         end else begin
            div_d = div_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
         busy_q <= 1'b0;
         bit_q  <= '0;
         n_q    <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
         busy_q <= busy_d;
         bit_q  <= bit_d;
         n_q    <= n_d;
         tx_q   <= tx_d;
         rx_q   <= rx_d;
      end
   end

   assign sclk    = sclk_q;
   assign mosi    = tx_q[63];
   assign busy    = busy_q;
   assign rx_word = rx_q;

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin share of one SPI bus between fetch and load/store ports.
// Ports: if_* fetch, d_* data, sclk/mosi/miso/cs1_n/cs2_n SPI pins.
// Option: define SPI_FAST_READ_EN for 0x0B flash reads with 8 dummy bits.
module spi_mem_arbiter
   import spi_arb_pkg::*;
#(
   parameter int DIV    = 1,
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_done,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs1_n,
   output logic              cs2_n
);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;

   logic        start, eng_busy, eng_last;
   logic        gnt_if, gnt_d, active;
   logic [6:0]  n_bits;
   logic [7:0]  cmd;
   logic [31:0] wswap, rx_word, rd_asm;
   logic [63:0] tx_word;

   // fetch wins a tie unless it was the last one served
   assign gnt_if = if_req && (!d_req || last_q == PORT_D);
   assign gnt_d  = d_req && !gnt_if;

   // byte 0 goes out first, each byte MSB first
   assign wswap = {wdata_q[7:0], wdata_q[15:8],
                   wdata_q[23:16], wdata_q[31:24]};

   always_comb begin
      cmd    = we_q ? CMD_WRITE : CMD_READ;
      n_bits = 7'd64;
      unique case (size_q)
         SZ_BYTE: n_bits = 7'd40;
         SZ_HALF: n_bits = 7'd48;
         default: n_bits = 7'd64;
      endcase
`ifdef SPI_FAST_READ_EN
      if (!we_q && !addr_q[23]) begin
         cmd    = CMD_FAST_READ;
         n_bits = n_bits + 7'd8;
      end
`endif
      tx_word = {cmd, 1'b0, addr_q[22:0], we_q ? wswap : 32'h0};
   end

   // last received byte sits lowest; swap back to little-endian
   always_comb begin
      unique case (size_q)
         SZ_BYTE: rd_asm = {24'h0, rx_word[7:0]};
         SZ_HALF: rd_asm = {16'h0, rx_word[7:0], rx_word[15:8]};
         default: rd_asm = {rx_word[7:0], rx_word[15:8],
                            rx_word[23:16], rx_word[31:24]};
      endcase
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      port_d     = port_q;
      we_d       = we_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      start      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_if) begin
               port_d  = PORT_IF;
               last_d  = PORT_IF;
               addr_d  = if_addr;
               we_d    = 1'b0;
               size_d  = SZ_WORD;
               state_d = ST_SETUP;
            end else if (gnt_d) begin
               port_d  = PORT_D;
               last_d  = PORT_D;
               addr_d  = d_addr;
               we_d    = d_we;
               size_d  = d_size;
               wdata_d = d_wdata;
               // flash is read-only: writes complete without bus traffic
               state_d = (d_we && !d_addr[23]) ? ST_FINISH : ST_SETUP;
            end
         end
         ST_SETUP: begin
            start   = 1'b1;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (eng_last || !eng_busy) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!we_q) begin
               if (port_q == PORT_IF) if_rdata_d = rd_asm;
               else                   d_rdata_d  = rd_asm;
            end
            state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_q     <= PORT_D;
         port_q     <= PORT_IF;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         port_q     <= port_d;
         we_q       <= we_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   spi_shift_engine #(.DIV(DIV)) u_eng (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .n_bits  (n_bits),
      .tx_word (tx_word),
      .miso    (miso),
      .sclk    (sclk),
      .mosi    (mosi),
      .busy    (eng_busy),
      .last    (eng_last),
      .rx_word (rx_word)
   );

   assign active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                   (state_q == ST_HOLD);
   assign cs1_n  = !(active && !addr_q[23]);
   assign cs2_n  = !(active && addr_q[23]);

   assign if_done  = (state_q == ST_FINISH) && (port_q == PORT_IF);
   assign d_done   = (state_q == ST_FINISH) && (port_q == PORT_D);
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Randomized bench for spi_mem_arbiter against a transaction-level model.
// Checks pins every cycle plus directed literal scenarios.
module tb_spi_mem_arbiter;

   localparam int DIV = 1;
`ifdef SPI_FAST_READ_EN
   localparam int          FETCH_DONE = 147;
   localparam logic [31:0] FETCH_HDR  = 32'h0B000100;
`else
   localparam int          FETCH_DONE = 131;
   localparam logic [31:0] FETCH_HDR  = 32'h03000100;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we, miso;
   logic [23:0] if_addr, d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata, if_rdata, d_rdata;
   logic        if_done, d_done, sclk, mosi, cs1_n, cs2_n;

   always #5 clk = ~clk;

   spi_mem_arbiter #(.DIV(DIV), .ADDR_W(24)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_size(d_size),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .sclk(sclk), .mosi(mosi), .miso(miso),
      .cs1_n(cs1_n), .cs2_n(cs2_n)
   );

   int n_chk = 0;
   int n_err = 0;

   // model expectations for the current cycle
   bit          chk_en = 0;
   logic        exp_cs1_n, exp_cs2_n, exp_sclk, exp_mosi;
   logic        exp_if_done, exp_d_done;
   bit          exp_mosi_v;
   logic [31:0] exp_if_rdata = 0, exp_d_rdata = 0;
   int          m_last = 1;  // 0 = fetch, 1 = data

   // observations
   int          cur_cyc, obs_done, obs_port;
   int          cs1_low, cs2_low, rises;
   logic [39:0] cap40;
   logic        sclk_prev = 1'b0;

   task automatic check(input string nm, input logic [71:0] act,
                        input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cur_cyc,
                  act, exp);
      end
   endtask

   task automatic idle_expect();
      exp_cs1_n   = 1'b1;
      exp_cs2_n   = 1'b1;
      exp_sclk    = 1'b0;
      exp_mosi    = 1'b0;
      exp_mosi_v  = 0;
      exp_if_done = 1'b0;
      exp_d_done  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cs1_n", cs1_n, exp_cs1_n);
         check("cs2_n", cs2_n, exp_cs2_n);
         check("sclk", sclk, exp_sclk);
         check("if_done", if_done, exp_if_done);
         check("d_done", d_done, exp_d_done);
         check("if_rdata", if_rdata, exp_if_rdata);
         check("d_rdata", d_rdata, exp_d_rdata);
         if (exp_mosi_v) check("mosi", mosi, exp_mosi);
      end
      if (!cs1_n) cs1_low++;
      if (!cs2_n) cs2_low++;
      if (sclk && !sclk_prev) begin
         rises++;
         if (rises <= 40) cap40 = {cap40[38:0], mosi};
      end
      sclk_prev = sclk;
      if (if_done) begin obs_done = cur_cyc; obs_port = 0; end
      if (d_done)  begin obs_done = cur_cyc; obs_port = 1; end
   end

   // Runs one transaction starting in the current IDLE cycle (cycle 0).
   task automatic run_one(input bit force_m, input logic [31:0] fm);
      int          win, nbytes, nb, ds, tt, s, b;
      logic [23:0] a, sa;
      logic        we;
      logic [1:0]  sz;
      logic [31:0] wd, rd;
      logic [7:0]  cmd;
      bit          drop, fast;
      bit          fb[72], fv[72], mb[72];
      if (if_req && d_req) win = (m_last == 1) ? 0 : 1;
      else if (if_req)     win = 0;
      else                 win = 1;
      m_last = win;
      if (win == 0) begin
         a = if_addr; we = 1'b0; sz = 2'd2; wd = '0;
      end else begin
         a = d_addr; we = d_we; sz = d_size; wd = d_wdata;
      end
      drop   = we && !a[23];
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      fast   = 0;
`ifdef SPI_FAST_READ_EN
      fast = !we && !a[23];
`endif
      nb  = 32 + 8 * nbytes + (fast ? 8 : 0);
      ds  = fast ? 40 : 32;
      cmd = we ? 8'h02 : (fast ? 8'h0B : 8'h03);
      sa  = {1'b0, a[22:0]};
      for (int i = 0; i < 72; i++) begin
         fb[i] = 0; fv[i] = 0; mb[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 8; i++)  begin fb[i] = cmd[7-i]; fv[i] = 1; end
      for (int i = 0; i < 24; i++) begin fb[8+i] = sa[23-i]; fv[8+i] = 1; end
      if (fast) for (int i = 32; i < 40; i++) fv[i] = 1;
      if (we)
         for (int k = 0; k < nbytes; k++)
            for (int j = 0; j < 8; j++) begin
               fb[ds+8*k+j] = wd[8*k+7-j];
               fv[ds+8*k+j] = 1;
            end
      if (force_m) for (int i = 0; i < 32; i++) mb[ds+i] = fm[31-i];
      rd = '0;
      for (int k = 0; k < nbytes; k++)
         for (int j = 0; j < 8; j++) rd[8*k+7-j] = mb[ds+8*k+j];
      tt = drop ? 1 : 3 + 2 * DIV * nb;
      obs_done = -1; obs_port = -1;
      cs1_low = 0; cs2_low = 0; rises = 0; cap40 = '0;
      for (int c = 0; c <= tt; c++) begin
         cur_cyc = c;
         idle_expect();
         if (!drop && c >= 1 && c <= tt - 1) begin
            if (a[23]) exp_cs2_n = 1'b0;
            else       exp_cs1_n = 1'b0;
         end
         if (!drop && c >= 2 && c < 2 + 2 * DIV * nb) begin
            s = c - 2;
            b = s / (2 * DIV);
            exp_sclk   = ((s % (2 * DIV)) >= DIV);
            exp_mosi   = fb[b];
            exp_mosi_v = fv[b];
            if (s % (2 * DIV) == 0) miso = mb[b];
         end
         if (c == tt) begin
            if (win == 0) exp_if_done = 1'b1;
            else          exp_d_done  = 1'b1;
            if (!we) begin
               if (win == 0) exp_if_rdata = rd;
               else          exp_d_rdata  = rd;
            end
         end
         if (c == 1) begin
            if (win == 0) if_addr = 24'($urandom);
            else begin
               d_addr  = 24'($urandom);
               d_wdata = $urandom;
               d_size  = 2'($urandom);
            end
         end
         @(posedge clk); #1;
      end
      if (win == 0) if_req = 1'b0;
      else          d_req  = 1'b0;
      cur_cyc = tt + 1;
      idle_expect();
   endtask

   initial begin
      rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; miso = 0;
      if_addr = '0; d_addr = '0; d_size = '0; d_wdata = '0;
      cur_cyc = 0;
      idle_expect();
      #12;
      check("rst cs1_n", cs1_n, 1'b1);
      check("rst cs2_n", cs2_n, 1'b1);
      check("rst sclk", sclk, 1'b0);
      check("rst mosi", mosi, 1'b0);
      check("rst if_done", if_done, 1'b0);
      check("rst d_done", d_done, 1'b0);
      check("rst if_rdata", if_rdata, 32'h0);
      check("rst d_rdata", d_rdata, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1;

      // directed fetch with known miso stream
      if_req = 1; if_addr = 24'h000100;
      run_one(1, 32'h13050000);
      check("fetch rdata", if_rdata, 32'h00000513);
      check("fetch done cyc", obs_done, FETCH_DONE);
      check("fetch cs1 low", cs1_low, FETCH_DONE - 1);
      check("fetch cs2 low", cs2_low, 0);
      check("fetch hdr", cap40[39:8], FETCH_HDR);

      // byte write to RAM
      d_req = 1; d_we = 1; d_size = 2'd0;
      d_addr = 24'h800010; d_wdata = 32'h123456A5;
      run_one(0, '0);
      check("bw frame", cap40, 40'h02000010A5);
      check("bw sclk pulses", rises, 40);
      check("bw done cyc", obs_done, 83);
      check("bw cs2 low", cs2_low, 82);
      check("bw cs1 low", cs1_low, 0);

      // write to flash is dropped
      d_req = 1; d_we = 1; d_size = 2'd2;
      d_addr = 24'h000004; d_wdata = 32'hDEADBEEF;
      run_one(0, '0);
      check("fw done cyc", obs_done, 1);
      check("fw port", obs_port, 1);
      check("fw sclk pulses", rises, 0);
      check("fw cs low", cs1_low + cs2_low, 0);

      // reset in the middle of a word read
      chk_en = 0;
      if_req = 1; if_addr = 24'h000200;
      repeat (50) @(posedge clk);
      #1;
      check("mid cs1 active", cs1_n, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid rst cs1_n", cs1_n, 1'b1);
      check("mid rst sclk", sclk, 1'b0);
      check("mid rst mosi", mosi, 1'b0);
      check("mid rst if_done", if_done, 1'b0);
      check("mid rst if_rdata", if_rdata, 32'h0);
      if_req = 0;
      m_last = 1; exp_if_rdata = '0; exp_d_rdata = '0;
      idle_expect();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;

      // both requests from reset: fetch, data, fetch
      if_req = 1; if_addr = 24'h000300;
      d_req = 1; d_we = 0; d_size = 2'd1; d_addr = 24'h800020;
      run_one(0, '0);
      check("rr1 port", obs_port, 0);
      check("rr1 done cyc", obs_done, FETCH_DONE);
      if_req = 1; if_addr = 24'h800040;
      run_one(0, '0);
      check("rr2 port", obs_port, 1);
      check("rr2 done cyc", obs_done, 99);
      d_req = 1; d_we = 1; d_size = 2'd3;
      d_addr = 24'h8000F0; d_wdata = 32'h01020304;
      run_one(0, '0);
      check("rr3 port", obs_port, 0);

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         if (!if_req && !d_req && $urandom_range(0, 3) == 0) begin
            idle_expect();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         if (!if_req && $urandom_range(0, 1) == 1) begin
            if_req = 1; if_addr = 24'($urandom);
         end
         if (!d_req && ($urandom_range(0, 1) == 1 || !if_req)) begin
            d_req = 1; d_we = 1'($urandom);
            d_size = 2'($urandom);
            d_addr = 24'($urandom); d_wdata = $urandom;
         end
         run_one(0, '0);
      end
      while (if_req || d_req) run_one(0, '0);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Shares the single SPI bus of the RV32E microcontroller between the instruction-fetch port and the load/store port, and sequences each SPI read/write transaction end to end. Address bit 23 selects the target device: flash on `cs1_n` (uo_out[4]) or RAM on `cs2_n` (uio_out[0]). `sclk`, `mosi` and `miso` map to uo_out[5], uo_out[3] and ui_in[2].

## Interface
- `DIV`, 1: SCLK half-period in `clk` cycles (≥1).
- `ADDR_W`, 24: SPI address width, fixed at 24.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `if_req` in 1: fetch request, level.
- `if_addr` in 24: fetch byte address.
- `if_rdata` out 32: fetched word.
- `if_done` out 1: fetch-complete pulse.
- `d_req` in 1: data request, level.
- `d_we` in 1: 1 = write.
- `d_size` in 2: 0 = byte, 1 = half, 2 or 3 = word.
- `d_addr` in 24: data byte address.
- `d_wdata` in 32: write data.
- `d_rdata` out 32: read data, zero-extended.
- `d_done` out 1: data-complete pulse.
- `sclk` out 1: SPI clock, mode 0.
- `mosi` out 1: SPI data out.
- `miso` in 1: SPI data in.
- `cs1_n` out 1: flash select, active-low.
- `cs2_n` out 1: RAM select, active-low.

## Operation
- **States:** IDLE → SETUP → SHIFT → HOLD → FINISH → IDLE.
- **Arbitration:** evaluated only in IDLE. Round-robin: when both requests are high, grant goes to the port not granted last. The last-grant flag resets to "data", so fetch wins the first tie.
- **Grant:** on grant, latch port, address, we, size and wdata. The device is `addr[23]`: 0 selects cs1, 1 selects cs2. The SPI address sent is `{1'b0, addr[22:0]}`.
- **Frame:** 8-bit command, then 24-bit address, then data. Every field is sent MSB first.
  - Command 0x03 = read, 0x02 = write.
  - Fetch is always a 4-byte read.
  - Data bytes are little-endian: byte 0 is transferred first. Write sends `wdata[7:0]` first.
- **Bit count:** N = 32 + 8·bytes.
- **SPI mode 0:** `sclk` idles low. `mosi` updates on each falling edge and is valid before the first rising edge. `miso` is sampled on each rising edge.
- **Read result:** assembled into bits [8·bytes−1:0]; upper bits are 0. The result is registered to the granted port's rdata in FINISH and held until that port's next FINISH.
- **Chip select:** the selected cs is low from SETUP through HOLD; both are high in IDLE and FINISH.
- **Done:** the granted port's done is high for exactly the FINISH cycle.
- **Write to flash** (`d_we=1`, `addr[23]=0`): dropped. IDLE goes directly to FINISH with no cs or sclk activity; rdata is unchanged.
- **Requester rule:** the requester must deassert req on the edge where it samples done=1. A req still high in the following IDLE cycle starts a new transaction.
- **Input stability:** changes to address, size or data while a request is granted are ignored.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- SETUP is cycle 1.
- SHIFT runs for 2·DIV·N cycles, starting at cycle 2.
- HOLD is cycle 2 + 2·DIV·N.
- done is high at cycle 3 + 2·DIV·N.
- Latency with DIV=1: word read = done at cycle 131; byte read = 83; dropped flash write = done at cycle 1.
- Back-to-back transactions: the next SETUP is no earlier than the cycle after the IDLE that follows FINISH.
- **Reset values, asynchronous:** `sclk`=0, `mosi`=0, `cs1_n`=1, `cs2_n`=1, `if_done`=`d_done`=0, `if_rdata`=`d_rdata`=0, state IDLE.
- **Reset mid-transaction:** the transaction is aborted immediately, with no done pulse; cs deasserts combinationally with reset.

## Configuration
- `SPI_FAST_READ_EN` defined: flash (cs1) reads use command 0x0B with 8 dummy bits after the address. Those reads have N = 40 + 8·bytes; fetch latency is DIV=1 → done at cycle 147. `mosi` = 0 during dummy bits. RAM reads are unchanged.
- Undefined: all reads use 0x03, and no dummy bits are sent.

## Structure
- **Package `spi_arb_pkg`:** state enum; command constants (READ 0x03, WRITE 0x02, FAST_READ 0x0B); size encodings; `PORT_IF`/`PORT_D` select constants.
- **Sub-module `spi_shift_engine`:**
  - owns the DIV counter, `sclk` generation, the 64-bit out/in shift registers and the bit counter;
  - interface: start, N, tx word, busy/last, rx word.
- **Arbiter top:** owns arbitration, latching, cs decode, byte assembly and done generation.

## Test plan
- Reset idle: `rst_n` low → cs1_n=cs2_n=1, sclk=0, done=0, rdata=0.
- Fetch 0x000100 with miso stream 0x13,0x05,0x00,0x00 after the address: `mosi` sends 0x03,0x00,0x01,0x00 → `if_rdata`=0x00000513, `if_done` at cycle 131, cs1_n low only for cycles 1–130.
- Byte write 0xA5 to 0x800010: cs2_n low; `mosi` = 0x02,0x00,0x00,0x10,0xA5; 40 sclk pulses; `d_done` at cycle 83.
- Both req high from reset: fetch is granted first, data next, then fetch again while both remain high.
- Flash write (`d_we=1`, addr 0x000004): `d_done` at cycle 1; no sclk edges; cs1_n and cs2_n stay 1.
- `rst_n` pulsed low at cycle 50 of a word read: cs1_n=1 immediately; no done; a new fetch after reset completes normally.
